hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Pipeline control block that drives the enable/flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers. It inspects the instruction held in IF/ID, the load in ID/EX and the data-memory busy signal. From these it generates PC/IF-ID stalls, ID/EX bubbles, IF/ID flushes on taken control transfers, and full-pipeline freezes during multi-cycle memory accesses. It sits beside the ID stage and is the producer of every stage-register `enable` in the core.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 1024: consecutive `mem_busy` cycles that trigger a memory timeout (≥2).
- `CNT_W`, default 16: width of the stall performance counter.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `if_id_instr`, input, 32: instruction currently in IF/ID (IF/ID data output).
- `id_ex_memread`, input, 1: instruction in ID/EX is a load.
- `id_ex_rt`, input, 5: destination register of the ID/EX load.
- `branch_taken`, input, 1: branch in ID resolved taken this cycle.
- `jump_id`, input, 1: J/JAL/JR in ID this cycle.
- `mem_busy`, input, 1: data memory not ready; MEM stage must hold.
- `pc_enable`, output, 1: PC register load enable.
- `if_id_enable`, output, 1: IF/ID load enable.
- `if_id_flush`, output, 1: IF/ID loads 32'h0 (NOP) at the next edge; overrides `if_id_enable`.
- `id_ex_enable`, output, 1: ID/EX load enable.
- `id_ex_bubble`, output, 1: ID/EX loads all-zero control (bubble) at the next edge.
- `ex_mem_enable`, output, 1: EX/MEM load enable.
- `mem_timeout`, output, 1: sticky timeout flag.
- `stall_cycles`, output, CNT_W: count of cycles with `pc_enable`=0.

## Operation

Decode of `if_id_instr`:
- op=[31:26], rs=[25:21], rt=[20:16].
- uses_rs = op ∉ {000010, 000011, 001111}.
- uses_rt = op ∈ {000000, 000100, 000101, 101011}.

Load-use hazard (lu):
- lu = `id_ex_memread` & `id_ex_rt`≠0 & ((uses_rs & rs==`id_ex_rt`) | (uses_rt & rt==`id_ex_rt`)).

State machine (states RUN, MEM_WAIT, HALT):
- RUN: `mem_busy`=1 → MEM_WAIT, wait counter ← 1; else stay in RUN.
- MEM_WAIT: `mem_busy`=0 → RUN. If `mem_busy`=1 and wait counter == TIMEOUT_CYCLES-1 → HALT. Otherwise increment the wait counter.
- HALT: stay until reset. `mem_timeout`=1.

Output decode (combinational from state and inputs), in priority order:
1. rst_n=0 or state HALT: all enables 0, `if_id_flush`=0, `id_ex_bubble`=0.
2. `mem_busy`=1 (any non-HALT state): all four enables 0, flush=0, bubble=0. The pipeline is frozen, so pending hazards stay in place and are re-evaluated after the freeze.
3. lu: `pc_enable`=0, `if_id_enable`=0, `id_ex_bubble`=1, `id_ex_enable`=1, `ex_mem_enable`=1, flush=0. A taken branch/jump in the same cycle is ignored; it is re-evaluated next cycle.
4. `branch_taken`|`jump_id`: `if_id_flush`=1, all enables 1, bubble=0.
5. Default: all enables 1, flush=0, bubble=0.

Counters:
- `stall_cycles` increments on every clock edge where `pc_enable`=0 and rst_n=1 (HALT included). It saturates at all-ones and never wraps.

## Timing

- Reset values: state RUN, wait counter 0, `stall_cycles` 0, `mem_timeout` 0. All enable outputs read 0 while rst_n=0, asynchronously.
- Zero-latency decode: outputs respond in the same cycle as the inputs; registers act at the next rising edge.
- A load-use stall lasts exactly 1 cycle, because the bubble clears `id_ex_memread` on the following cycle.
- A flush lasts 1 cycle per taken transfer.
- Memory freeze: for N cycles of `mem_busy`, enables are low for exactly those N cycles. HALT is reached on the edge that completes TIMEOUT_CYCLES consecutive busy cycles, and `mem_timeout` rises in the following cycle.
- `mem_busy` deasserting in the same cycle as the timeout edge: no timeout; return to RUN.
- rst_n asserted mid-freeze or in HALT: immediate return to reset values. Pipeline resumes on the first edge after release.

## Test plan

- Load-use: ID/EX `lw $5`, `id_ex_memread`=1, IF/ID `add $6,$5,$7` (32'h00A73020) → one cycle of `pc_enable`=0, `if_id_enable`=0, `id_ex_bubble`=1; `stall_cycles`=1. Repeat with `id_ex_rt`=0 → no stall.
- Taken branch: `branch_taken`=1 for one cycle, no hazard → `if_id_flush`=1 for that cycle, all enables 1.
- Priority: lu and `branch_taken` both set → stall only, flush=0. Next cycle (lu cleared, branch still taken) → flush=1.
- Memory wait: `mem_busy` high 5 cycles → all enables 0 for exactly 5 cycles, `stall_cycles`=5, state back to RUN.
- Timeout: TIMEOUT_CYCLES=4, `mem_busy` held → `mem_timeout`=1 after 4 busy cycles; enables stay 0 after `mem_busy` drops. Reset pulse clears the flag.
- Reset mid-freeze: rst_n low during MEM_WAIT → enables 0 immediately; after release with `mem_busy`=0 → enables 1, `stall_cycles`=0.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Hazard/stall controller: produces every pipeline-register enable, load-use bubbles,
// IF/ID flushes on taken transfers and full freezes while data memory is busy.
module hazard_stall_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_id_instr,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rt,
  input  logic             branch_taken,
  input  logic             jump_id,
  input  logic             mem_busy,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_enable,
  output logic             id_ex_bubble,
  output logic             ex_mem_enable,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic [5:0] op;
  logic [4:0] rs, rt;
  logic       uses_rs, uses_rt, lu;

  // IF/ID source-operand decode and load-use detection
  always_comb begin
    op      = if_id_instr[31:26];
    rs      = if_id_instr[25:21];
    rt      = if_id_instr[20:16];
    uses_rs = !((op == 6'b000010) || (op == 6'b000011) || (op == 6'b001111));
    uses_rt = (op == 6'b000000) || (op == 6'b000100) ||
              (op == 6'b000101) || (op == 6'b101011);
    lu      = id_ex_memread && (id_ex_rt != 5'd0) &&
              ((uses_rs && (rs == id_ex_rt)) || (uses_rt && (rt == id_ex_rt)));
  end

  // Next-state: wait_q counts consecutive busy cycles already completed
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_busy) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // Output decode; reset gates the enables asynchronously
  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_enable  = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_enable = 1'b1;
    if (!rst_n || (state_q == HALT) || mem_busy) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
    end else if (lu) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (branch_taken || jump_id) begin
      if_id_flush = 1'b1;
    end
  end

  // Saturating stall counter
  always_comb begin
    stall_d = stall_q;
    if (!pc_enable && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign mem_timeout  = (state_q == HALT);
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a default instance plus a TIMEOUT_CYCLES=4,
// CNT_W=3 instance sharing the same inputs for timeout and saturation behaviour.
module tb_hazard_stall_unit;

  typedef enum int {M_RUN, M_FRZ, M_LU, M_FLUSH, M_HALT} mode_e;

  typedef struct {
    mode_e       m;
    mode_e       m4;
    logic        tmo4;
    logic [15:0] stall;
    logic [2:0]  stall4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_id_instr;
  logic        id_ex_memread;
  logic [4:0]  id_ex_rt;
  logic        branch_taken;
  logic        jump_id;
  logic        mem_busy;

  logic        pc_en, ifid_en, ifid_fl, idex_en, idex_bub, exmem_en, tmo;
  logic [15:0] stall;
  logic        pc_en4, ifid_en4, ifid_fl4, idex_en4, idex_bub4, exmem_en4, tmo4;
  logic [2:0]  stall4;

  int          vectors = 0;
  int          miscompares = 0;
  logic        chk4 = 1'b0;
  logic [15:0] exp_stall = '0;
  logic [2:0]  exp_stall4 = '0;
  exp_t        sb[$];

  localparam logic [31:0] ADD_6_5_7 = 32'h00A73020;
  localparam logic [31:0] SW_RT5    = 32'hAC050000;
  localparam logic [31:0] J_RS5     = 32'h08A00000;
  localparam logic [31:0] LUI_RT5   = 32'h3C050000;
  localparam logic [31:0] ADDI_RT5  = 32'h20050001;

  hazard_stall_unit dut (
    .clk(clk), .rst_n(rst_n), .if_id_instr(if_id_instr), .id_ex_memread(id_ex_memread),
    .id_ex_rt(id_ex_rt), .branch_taken(branch_taken), .jump_id(jump_id), .mem_busy(mem_busy),
    .pc_enable(pc_en), .if_id_enable(ifid_en), .if_id_flush(ifid_fl), .id_ex_enable(idex_en),
    .id_ex_bubble(idex_bub), .ex_mem_enable(exmem_en), .mem_timeout(tmo), .stall_cycles(stall)
  );

  hazard_stall_unit #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .if_id_instr(if_id_instr), .id_ex_memread(id_ex_memread),
    .id_ex_rt(id_ex_rt), .branch_taken(branch_taken), .jump_id(jump_id), .mem_busy(mem_busy),
    .pc_enable(pc_en4), .if_id_enable(ifid_en4), .if_id_flush(ifid_fl4), .id_ex_enable(idex_en4),
    .id_ex_bubble(idex_bub4), .ex_mem_enable(exmem_en4), .mem_timeout(tmo4), .stall_cycles(stall4)
  );

  always #5 clk = ~clk;

  // {pc, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en}
  function automatic logic [5:0] pat(input mode_e m);
    case (m)
      M_RUN:   pat = 6'b110101;
      M_LU:    pat = 6'b000111;
      M_FLUSH: pat = 6'b111101;
      default: pat = 6'b000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic [31:0] ins, input logic mr, input logic [4:0] rt,
                     input logic br, input logic jm, input logic bz,
                     input mode_e m, input mode_e m4, input logic t4);
    exp_t e;
    @(negedge clk);
    if_id_instr = ins; id_ex_memread = mr; id_ex_rt = rt;
    branch_taken = br; jump_id = jm; mem_busy = bz;
    e.m = m; e.m4 = m4; e.tmo4 = t4; e.stall = exp_stall; e.stall4 = exp_stall4;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    chk("ctl", 32'({pc_en, ifid_en, ifid_fl, idex_en, idex_bub, exmem_en}), 32'(pat(e.m)));
    chk("stall_cycles", 32'(stall), 32'(e.stall));
    chk("mem_timeout", 32'(tmo), 32'(0));
    if (chk4) begin
      chk("ctl_t4", 32'({pc_en4, ifid_en4, ifid_fl4, idex_en4, idex_bub4, exmem_en4}),
          32'(pat(e.m4)));
      chk("stall_cycles_t4", 32'(stall4), 32'(e.stall4));
      chk("mem_timeout_t4", 32'(tmo4), 32'(e.tmo4));
    end
    if (!pat(m)[5] && (exp_stall != 16'hFFFF)) exp_stall = exp_stall + 16'd1;
    if (chk4 && !pat(m4)[5] && (exp_stall4 != 3'd7)) exp_stall4 = exp_stall4 + 3'd1;
  endtask

  // Asserts reset mid-cycle with current inputs held, checks the async effect, then releases
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", 32'({pc_en, ifid_en, ifid_fl, idex_en, idex_bub, exmem_en}), 32'(0));
    chk("rst_stall", 32'(stall), 32'(0));
    chk("rst_tmo", 32'(tmo), 32'(0));
    chk("rst_ctl_t4", 32'({pc_en4, ifid_en4, ifid_fl4, idex_en4, idex_bub4, exmem_en4}), 32'(0));
    chk("rst_tmo_t4", 32'(tmo4), 32'(0));
    chk("rst_stall_t4", 32'(stall4), 32'(0));
    @(negedge clk);
    if_id_instr = '0; id_ex_memread = 1'b0; id_ex_rt = '0;
    branch_taken = 1'b0; jump_id = 1'b0; mem_busy = 1'b0;
    rst_n = 1'b1;
    exp_stall = '0;
    exp_stall4 = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    if_id_instr = '0; id_ex_memread = 1'b0; id_ex_rt = '0;
    branch_taken = 1'b0; jump_id = 1'b0; mem_busy = 1'b0;
    do_reset();

    // Load-use on rs, then bubble clears memread
    cyc(ADD_6_5_7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, M_LU,  M_LU,  1'b0);
    cyc(ADD_6_5_7, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, M_RUN, M_RUN, 1'b0);
    cyc(ADD_6_5_7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, M_RUN, M_RUN, 1'b0);
    // rt use, and opcodes that must not use rs/rt
    cyc(ADD_6_5_7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, M_LU,  M_LU,  1'b0);
    cyc(SW_RT5,    1'b1, 5'd5, 1'b0, 1'b0, 1'b0, M_LU,  M_LU,  1'b0);
    cyc(J_RS5,     1'b1, 5'd5, 1'b0, 1'b0, 1'b0, M_RUN, M_RUN, 1'b0);
    cyc(LUI_RT5,   1'b1, 5'd5, 1'b0, 1'b0, 1'b0, M_RUN, M_RUN, 1'b0);
    cyc(ADDI_RT5,  1'b1, 5'd5, 1'b0, 1'b0, 1'b0, M_RUN, M_RUN, 1'b0);
    cyc(ADD_6_5_7, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, M_RUN, M_RUN, 1'b0);

    // Taken branch and jump flush
    cyc(ADD_6_5_7, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, M_FLUSH, M_FLUSH, 1'b0);
    cyc(ADD_6_5_7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, M_RUN,   M_RUN,   1'b0);
    cyc(ADD_6_5_7, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, M_FLUSH, M_FLUSH, 1'b0);

    // Load-use outranks a taken branch; branch re-evaluated next cycle
    cyc(ADD_6_5_7, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, M_LU,    M_LU,    1'b0);
    cyc(ADD_6_5_7, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, M_FLUSH, M_FLUSH, 1'b0);

    // Five-cycle memory freeze with a pending hazard held in place
    for (int i = 0; i < 5; i++)
      cyc(ADD_6_5_7, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, M_FRZ, M_FRZ, 1'b0);
    cyc(ADD_6_5_7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, M_LU,  M_LU,  1'b0);
    cyc(ADD_6_5_7, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, M_RUN, M_RUN, 1'b0);

    // Timeout on the 4-cycle instance; counter saturates at 7 in HALT
    do_reset();
    chk4 = 1'b1;
    for (int i = 0; i < 4; i++)
      cyc(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, M_FRZ, M_FRZ, 1'b0);
    for (int i = 0; i < 6; i++)
      cyc(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, M_RUN, M_HALT, 1'b1);

    // Reset from HALT; busy ends just short of the timeout
    do_reset();
    cyc(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, M_RUN, M_RUN, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, M_FRZ, M_FRZ, 1'b0);
    cyc(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, M_RUN, M_RUN, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, M_FRZ, M_FRZ, 1'b0);
    cyc(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, M_RUN, M_HALT, 1'b1);

    // Reset mid-freeze must also clear the wait counter
    do_reset();
    for (int i = 0; i < 2; i++)
      cyc(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, M_FRZ, M_FRZ, 1'b0);
    do_reset();
    cyc(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, M_RUN, M_RUN, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, M_FRZ, M_FRZ, 1'b0);
    cyc(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, M_RUN, M_RUN, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
